vga_fb_reader: RTL and testbench

//  Display-side consumer of the 320x240 BlockRAM frame buffer filled by the pattern/Mandelbrot writers.

---
 rtl/vga_fb_reader.sv | 196 +++++++++++++++++++
 tb/tb_vga_fb_reader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_fb_reader: 640x480@60 VGA scan-out of a 320x240 BRAM frame buffer with  |
// | SCALE x SCALE upscale. Optional white test border: FB_TEST_BORDER_EN.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_fb_reader #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int COLUMNS    = 320,
  parameter int SCALE      = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pix_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_hsync,
  output logic                  o_vsync,
  output logic [3:0]            o_red,
  output logic [3:0]            o_green,
  output logic [3:0]            o_blue,
  output logic                  o_frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [H_W-1:0]        c_h_vis      = H_W'(H_VISIBLE);
  localparam logic [H_W-1:0]        c_h_vis_last = H_W'(H_VISIBLE - 1);
  localparam logic [H_W-1:0]        c_h_last     = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]        c_hs_start   = H_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_W-1:0]        c_hs_end     = H_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_W-1:0]        c_v_vis      = V_W'(V_VISIBLE);
  localparam logic [V_W-1:0]        c_v_vis_last = V_W'(V_VISIBLE - 1);
  localparam logic [V_W-1:0]        c_v_last     = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]        c_vs_start   = V_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_W-1:0]        c_vs_end     = V_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SUB_W-1:0]      c_sub_last   = SUB_W'(SCALE - 1);
  localparam logic [ADDR_WIDTH-1:0] c_cols       = ADDR_WIDTH'(COLUMNS);

  logic [H_W-1:0]        h_cnt_q, h_cnt_d;
  logic [V_W-1:0]        v_cnt_q, v_cnt_d;
  logic [SUB_W-1:0]      h_sub_q, h_sub_d;
  logic [SUB_W-1:0]      v_sub_q, v_sub_d;
  logic [ADDR_WIDTH-1:0] fb_col_q, fb_col_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  active1_q, active1_d;
  logic                  hs1_q, hs1_d;
  logic                  vs1_q, vs1_d;
  logic [11:0]           rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  frame_start_q, frame_start_d;
`ifdef FB_TEST_BORDER_EN
  logic                  border1_q, border1_d;
`endif

  logic w_h_vis, w_v_vis, w_active, w_hs, w_vs;
  assign w_h_vis  = (h_cnt_q < c_h_vis);
  assign w_v_vis  = (v_cnt_q < c_v_vis);
  assign w_active = w_h_vis && w_v_vis;
  assign w_hs     = (h_cnt_q >= c_hs_start) && (h_cnt_q < c_hs_end);
  assign w_vs     = (v_cnt_q >= c_vs_start) && (v_cnt_q < c_vs_end);

  always_comb begin
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    h_sub_d       = h_sub_q;
    v_sub_d       = v_sub_q;
    fb_col_d      = fb_col_q;
    row_base_d    = row_base_q;
    rd_addr_d     = rd_addr_q;
    active1_d     = active1_q;
    hs1_d         = hs1_q;
    vs1_d         = vs1_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    frame_start_d = 1'b0;
`ifdef FB_TEST_BORDER_EN
    border1_d     = border1_q;
`endif
    if (i_pix_en) begin
      // Address is only sampled while visible, so it holds through blanking
      if (w_active) rd_addr_d = row_base_q + fb_col_q;
      active1_d = w_active;
      hs1_d     = w_hs;
      vs1_d     = w_vs;
      hsync_d   = ~hs1_q;
      vsync_d   = ~vs1_q;
`ifdef FB_TEST_BORDER_EN
      border1_d = w_active && ((h_cnt_q == '0) || (h_cnt_q == c_h_vis_last) ||
                               (v_cnt_q == '0) || (v_cnt_q == c_v_vis_last));
      rgb_d     = !active1_q ? 12'h000 : (border1_q ? 12'hFFF : i_rd_data[11:0]);
`else
      rgb_d     = active1_q ? i_rd_data[11:0] : 12'h000;
`endif

      if (w_h_vis) begin
        if (h_sub_q == c_sub_last) begin
          h_sub_d  = '0;
          fb_col_d = fb_col_q + 1'b1;
        end else begin
          h_sub_d  = h_sub_q + 1'b1;
        end
      end

      if (h_cnt_q == c_h_last) begin
        h_cnt_d  = '0;
        h_sub_d  = '0;
        fb_col_d = '0;
        if (w_v_vis) begin
          if (v_sub_q == c_sub_last) begin
            v_sub_d    = '0;
            row_base_d = row_base_q + c_cols;
          end else begin
            v_sub_d    = v_sub_q + 1'b1;
          end
        end
        if (v_cnt_q == c_v_last) begin
          v_cnt_d       = '0;
          v_sub_d       = '0;
          row_base_d    = '0;
          frame_start_d = 1'b1;
        end else begin
          v_cnt_d = v_cnt_q + 1'b1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      h_sub_q       <= '0;
      v_sub_q       <= '0;
      fb_col_q      <= '0;
      row_base_q    <= '0;
      rd_addr_q     <= '0;
      active1_q     <= 1'b0;
      hs1_q         <= 1'b0;
      vs1_q         <= 1'b0;
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
`ifdef FB_TEST_BORDER_EN
      border1_q     <= 1'b0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      h_sub_q       <= h_sub_d;
      v_sub_q       <= v_sub_d;
      fb_col_q      <= fb_col_d;
      row_base_q    <= row_base_d;
      rd_addr_q     <= rd_addr_d;
      active1_q     <= active1_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
`ifdef FB_TEST_BORDER_EN
      border1_q     <= border1_d;
`endif
    end
  end

  assign o_rd_addr     = rd_addr_q;
  assign o_hsync       = hsync_q;
  assign o_vsync       = vsync_q;
  assign o_red         = rgb_q[11:8];
  assign o_green       = rgb_q[7:4];
  assign o_blue        = rgb_q[3:0];
  assign o_frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_fb_reader: directed self-checking bench for vga_fb_reader, using a   |
// | shrunken 24x12 raster (16x8 visible, SCALE 2) to keep frames short.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_vga_fb_reader;

  localparam int HV = 16, HF = 2, HS = 4, HB = 2;
  localparam int VV = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int COLS = 8, SC = 2;
`ifdef FB_TEST_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [16:0] rd_addr;
  logic [11:0] rd_data = 12'h000;
  logic        hsync, vsync, frame_start;
  logic [3:0]  red, green, blue;
  int          mode = 0;

  int n_tests = 0, n_fail = 0;
  int m_h, m_v, m_ph, m_pv;
  bit m_act1, m_hs1, m_vs1, m_bord1;
  int m_addr;
  int hs_low, vs_low, fs_cnt, run, run_max, blank_bad, act_fff;
  int tick_idx, last_fall, period;
  bit prev_hs;

  vga_fb_reader #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLUMNS(COLS), .SCALE(SC), .ADDR_WIDTH(17), .DATA_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .i_pix_en(pix_en),
    .o_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_hsync(hsync), .o_vsync(vsync),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bram(input int md, input logic [16:0] a);
    if (md == 0) return a[11:0];
    if (md == 1) return 12'hFFF;
    return 12'h000;
  endfunction

  always @(posedge clk) rd_data <= bram(mode, rd_addr);

  function automatic bit is_active(input int h, input int v);
    return (h < HV) && (v < VV);
  endfunction

  function automatic bit is_border(input int h, input int v);
    return is_active(h, v) && (h == 0 || h == HV - 1 || v == 0 || v == VV - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, got, exp, m_h, m_v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One pix_en pulse; returns half a clock after the active edge.
  task automatic tick();
    @(negedge clk) pix_en = 1'b1;
    @(negedge clk) pix_en = 1'b0;
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_ph = -1; m_pv = -1;
    m_act1 = 0; m_hs1 = 0; m_vs1 = 0; m_bord1 = 0; m_addr = 0;
  endtask

  task automatic directed(input int h, input int v, input logic [11:0] got);
    logic [11:0] e;
    bit hit;
    hit = 1'b1;
    e = 12'h000;
    if (mode == 0) begin
      if ((h == 0 || h == 1) && (v == 0 || v == 1)) e = 12'd0;
      else if (h == 2 && v == 0) e = 12'd1;
      else if (h == 0 && v == 2) e = 12'd8;
      else if (h == HV - 1 && v == VV - 1) e = 12'd31;
      else hit = 1'b0;
    end else if (mode == 2) begin
      if (!((h == 1 && v == 1) || (h == 0 && v == 0) || (h == HV - 1 && v == VV - 1)))
        hit = 1'b0;
    end else begin
      if (!(h == 5 && v == 3)) hit = 1'b0;
      e = 12'hFFF;
    end
    if (BORDER && is_border(h, v)) e = 12'hFFF;
    if (hit) check_eq($sformatf("pixel(%0d,%0d)", h, v), got, e);
  endtask

  task automatic step();
    int h, v;
    logic [11:0] exp_rgb, got_rgb;
    h = m_h; v = m_v;
    tick();
    got_rgb = {red, green, blue};
    exp_rgb = !m_act1 ? 12'h000 : (m_bord1 ? 12'hFFF : bram(mode, m_addr[16:0]));
    check_eq("rgb", got_rgb, exp_rgb);
    check_eq("hsync", hsync, !m_hs1);
    check_eq("vsync", vsync, !m_vs1);
    check_eq("frame_start", frame_start, (h == HT - 1) && (v == VT - 1));
    if (is_active(h, v)) m_addr = (v / SC) * COLS + h / SC;
    check_eq("rd_addr", rd_addr, m_addr);
    if (m_ph >= 0 && m_act1) directed(m_ph, m_pv, got_rgb);

    if (!hsync) begin hs_low++; run++; if (run > run_max) run_max = run; end else run = 0;
    if (prev_hs && !hsync) begin
      if (last_fall >= 0) period = tick_idx - last_fall;
      last_fall = tick_idx;
    end
    prev_hs = hsync;
    if (!vsync) vs_low++;
    if (frame_start) fs_cnt++;
    if (!m_act1 && got_rgb != 12'h000) blank_bad++;
    if (m_act1 && got_rgb == 12'hFFF) act_fff++;
    tick_idx++;

    m_act1 = is_active(h, v);
    m_hs1  = (h >= HV + HF) && (h < HV + HF + HS);
    m_vs1  = (v >= VV + VF) && (v < VV + VF + VS);
    m_bord1 = BORDER && is_border(h, v);
    m_ph = h; m_pv = v;
    if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic clear_stats();
    hs_low = 0; vs_low = 0; fs_cnt = 0; run = 0; run_max = 0;
    blank_bad = 0; act_fff = 0; tick_idx = 0; last_fall = -1; period = 0; prev_hs = 1'b1;
  endtask

  task automatic run_frame(input string name);
    clear_stats();
    repeat (HT * VT) step();
    check_eq({name, ":hsync_low_ticks"}, hs_low, HS * VT);
    check_eq({name, ":hsync_width"}, run_max, HS);
    check_eq({name, ":hsync_period"}, period, HT);
    check_eq({name, ":vsync_low_ticks"}, vs_low, VS * HT);
    check_eq({name, ":frame_start_count"}, fs_cnt, 1);
    check_eq({name, ":blank_rgb"}, blank_bad, 0);
  endtask

  task automatic check_reset_pins(input string name);
    check_eq({name, ":hsync"}, hsync, 1'b1);
    check_eq({name, ":vsync"}, vsync, 1'b1);
    check_eq({name, ":rgb"}, {red, green, blue}, 12'h000);
    check_eq({name, ":rd_addr"}, rd_addr, 17'd0);
    check_eq({name, ":frame_start"}, frame_start, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_stats();
    idle(1);
    // Reset held with pix_en pulses every 4 clocks
    for (int i = 0; i < 2; i++) begin
      tick();
      check_reset_pins("in_reset");
      idle(2);
    end
    rst = 1'b0;
    model_reset();
    step();
    check_eq("after_rst:rd_addr", rd_addr, 17'd0);
    check_eq("after_rst:rgb", {red, green, blue}, 12'h000);
    while (!(m_h == 0 && m_v == 0)) step();

    run_frame("addr_frame");

    mode = 1;
    idle(2);
    run_frame("white_frame");
    check_eq("white_frame:active_fff", act_fff, BORDER ? HV * VV : HV * VV);

    mode = 2;
    idle(2);
    run_frame("black_frame");
    check_eq("black_frame:active_fff", act_fff, BORDER ? 2 * HV + 2 * VV - 4 : 0);

    // Mid-frame reset
    mode = 0;
    idle(2);
    while (!(m_h == 10 && m_v == 5)) step();
    rst = 1'b1;
    tick();
    check_reset_pins("mid_rst");
    rst = 1'b0;
    model_reset();
    clear_stats();
    step();
    check_eq("mid_rst_release:rd_addr", rd_addr, 17'd0);
    check_eq("mid_rst_release:frame_start", frame_start, 1'b0);
    while (!(m_h == 0 && m_v == 0)) step();
    check_eq("mid_rst:frame_start_count", fs_cnt, 1);
    idle(1);
    check_eq("frame_start_clears", frame_start, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
